// File: rtl/fir_stream_engine.sv
// Streaming 11-tap FIR stage: circular sample buffer in the data BRAM, one MAC pass per sample.
// Define FIR_SAT_EN for a saturating accumulator; the default build wraps.
module fir_stream_engine #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   tlast_err,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    input  logic                   sm_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);

    localparam int unsigned IdxW = $clog2(Tape_Num + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Tape_Num - 1);
    localparam logic [IdxW-1:0] NumIdx  = IdxW'(Tape_Num);

    typedef enum logic [2:0] {StIdle, StClear, StWaitIn, StMac, StOut, StDone} state_e;

    state_e                 state_q, state_d;
    logic [31:0]            len_q, len_d, cnt_q, cnt_d;
    logic [IdxW-1:0]        wp_q, wp_d, k_q, k_d;
    logic [pDATA_WIDTH-1:0] acc_q, acc_d;
    logic                   last_in_q, last_in_d, done_q, done_d, err_q, err_d;

    logic [pDATA_WIDTH-1:0] prod, acc_sum;
    logic [IdxW-1:0]        rd_idx, data_idx;
    logic                   out_last;

    assign prod     = tap_Do * data_Do;
    assign rd_idx   = (wp_q >= k_q) ? (wp_q - k_q) : (wp_q + NumIdx - k_q);
    assign out_last = (cnt_q + 32'd1) == len_q;

`ifdef FIR_SAT_EN
    logic [pDATA_WIDTH:0] sum_ext;
    always_comb begin
        sum_ext = {acc_q[pDATA_WIDTH-1], acc_q} + {prod[pDATA_WIDTH-1], prod};
        if (sum_ext[pDATA_WIDTH] != sum_ext[pDATA_WIDTH-1]) begin
            acc_sum = sum_ext[pDATA_WIDTH] ? {1'b1, {(pDATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(pDATA_WIDTH-1){1'b1}}};
        end else begin
            acc_sum = sum_ext[pDATA_WIDTH-1:0];
        end
    end
`else
    assign acc_sum = acc_q + prod;
`endif

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wp_d      = wp_q;
        k_d       = k_q;
        acc_d     = acc_q;
        last_in_d = last_in_q;
        done_d    = done_q;
        err_d     = err_q;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        tap_EN    = 1'b0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_idx  = '0;
        unique case (state_q)
            StIdle: begin
                if (ap_start) begin
                    len_d   = data_length;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    wp_d    = '0;
                    k_d     = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                data_EN  = 1'b1;
                data_WE  = 4'hF;
                data_idx = k_q;
                if (k_q == LastIdx) begin
                    k_d     = '0;
                    state_d = (len_q == 32'd0) ? StDone : StWaitIn;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StWaitIn: begin
                ss_tready = 1'b1;
                data_idx  = wp_q;
                if (ss_tvalid) begin
                    data_EN   = 1'b1;
                    data_WE   = 4'hF;
                    last_in_d = ss_tlast;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = StMac;
                end
            end
            StMac: begin
                // Read k is issued at k_q == k; its product lands one cycle later.
                if (k_q != NumIdx) begin
                    tap_EN   = 1'b1;
                    data_EN  = 1'b1;
                    data_idx = rd_idx;
                end
                if (k_q != '0) begin
                    acc_d = acc_sum;
                end
                if (k_q == NumIdx) begin
                    k_d     = '0;
                    state_d = StOut;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StOut: begin
                sm_tvalid = 1'b1;
                if (sm_tready) begin
                    cnt_d = cnt_q + 32'd1;
                    wp_d  = (wp_q == LastIdx) ? '0 : wp_q + 1'b1;
                    if (last_in_q != out_last) begin
                        err_d = 1'b1;
                    end
                    state_d = out_last ? StDone : StWaitIn;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            wp_q      <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            last_in_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            last_in_q <= last_in_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ap_idle   = (state_q == StIdle);
    assign ap_done   = done_q;
    assign tlast_err = err_q;
    assign sm_tdata  = acc_q;
    assign sm_tlast  = (state_q == StOut) && out_last;
    assign tap_A     = pADDR_WIDTH'(k_q) << 2;
    assign data_A    = pADDR_WIDTH'(data_idx) << 2;
    assign data_Di   = (state_q == StWaitIn) ? ss_tdata : '0;

endmodule
